servant_uart_rx: RTL and testbench
==================================

# servant_uart_rx

Wishbone-slave UART receiver peripheral for the servant SoC: the receive counterpart of the UART transmit path. Samples the asynchronous serial input `i_rx` (8N1, LSB first), deserialises bytes and buffers them in a small FIFO. Exposes data and status registers to the CPU over the same single-cycle-ack Wishbone subset the servant RAM uses. Sits on the peripheral bus beside the RAM and raises `o_irq` while data is pending.

## Interface
- `CLKS_PER_BIT`, 139, clock cycles per serial bit (16 MHz / 115200); must be ≥ 4
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2 (ignored when FIFO disabled)
- `RESET_STRATEGY`, "", "NONE" is accepted but ignored; the reset below is always applied
- `i_wb_clk`  in  1  sole clock
- `i_wb_rst_n`  in  1  asynchronous, active-low reset
- `i_wb_adr`  in  1  register select (0 = RXDATA, 1 = STATUS); bus address bit 2
- `i_wb_dat`  in  32  write data (STATUS only)
- `i_wb_we`  in  1  write enable
- `i_wb_cyc`  in  1  cycle/strobe
- `o_wb_rdt`  out  32  registered read data
- `o_wb_ack`  out  1  acknowledge
- `i_rx`  in  1  asynchronous serial input, idle high
- `o_irq`  out  1  high while FIFO is non-empty

## Operation
- `i_rx` passes through a 2-flop synchroniser (reset to 1). The FSM uses `rx_s` and its previous value `rx_q`.
- States: IDLE, START, DATA, STOP. Bit counter is 3 bits. Baud counter is $clog2(CLKS_PER_BIT) bits.
- IDLE: on falling edge (`rx_q`=1, `rx_s`=0) clear the baud counter and go to START.
- START: at count CLKS_PER_BIT/2−1, sample `rx_s`. If it is 0, clear the counter and go to DATA. If it is 1, the edge was a glitch: return to IDLE.
- DATA: every CLKS_PER_BIT cycles, shift `rx_s` into bit[idx], LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - If 1: push the byte and return to IDLE.
  - If 0: set sticky FERR, discard the byte and return to IDLE.
  - IDLE needs a falling edge to restart, so a held break produces one FERR only.
- Push when FIFO is full: byte dropped, sticky OVR set.
- RXDATA read: `o_wb_rdt` = {24'b0, head byte}, and the head is popped on the ack cycle. Read when empty returns 0 and does not pop.
- STATUS read: bit0 VALID (non-empty), bit1 OVR, bit2 FERR, bit3 FULL, bits[15:8] fill level, other bits 0.
- STATUS write: writing 1 to bit1/bit2 clears OVR/FERR (W1C). Other bits ignored.
- RXDATA write: acked, no effect.
- Push and pop in the same cycle when full: both happen, no OVR.
- A sticky flag set and W1C-cleared in the same cycle ends up set.

## Timing
- Reset values: `o_wb_ack`=0, `o_wb_rdt`=0, `o_irq`=0, FSM=IDLE, FIFO empty, OVR=FERR=0.
- `o_wb_ack` <= `i_wb_cyc & !o_wb_ack`: one-cycle pulse one clock after cyc. Back-to-back accesses need cyc deasserted or re-sampled.
- `o_wb_rdt` is registered in the same edge that raises ack. Pop occurs at that edge, exactly once per ack.
- Byte available: VALID/`o_irq` rise 1 cycle after the stop-bit sample. That is ≈ 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the `i_rx` falling edge.
- Reset mid-frame aborts immediately. The partial byte is lost and the FIFO is cleared.

## Configuration
- `SERVANT_UART_RX_FIFO_EN` defined: FIFO of FIFO_DEPTH entries; fill level reported in STATUS[15:8].
- Not defined: single holding register, behaving as FIFO_DEPTH=1. FULL equals VALID. STATUS[15:8] = {7'b0, VALID}.
- Register map, flags and timing are identical in both builds.

## Structure
- Package `servant_uart_pkg` holds:
  - FSM state enum (IDLE/START/DATA/STOP)
  - register offsets (RXDATA=0, STATUS=1)
  - STATUS bit-position constants
- Sub-module `servant_uart_rx_fifo`: sync FIFO with push/pop/full/empty/level. The top instantiates it only under the macro.

## Test plan
- CLKS_PER_BIT=8: send 0xA5 at 8 clocks/bit → VALID=1 after ≈78 cycles; RXDATA read returns 0x000000A5; next STATUS has VALID=0.
- 1-cycle low glitch on `i_rx` → FSM returns to IDLE; VALID stays 0; FERR stays 0.
- Frame 0x3C with stop bit 0 → FERR=1, FIFO empty; STATUS write 0x4 → FERR=0.
- FIFO_EN, depth 4: send 0x01..0x05 without reading → level=4, OVR=1; reads return 0x01..0x04 in order.
- Read RXDATA while empty → returns 0, ack after one cycle, level stays 0.
- Assert `i_wb_rst_n` low during DATA bit 3 → all outputs 0 asynchronously; next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/servant_uart_pkg.sv
// Shared definitions for the servant UART receiver: FSM states, register map
// and STATUS layout.
`timescale 1ns/1ps
package servant_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic REG_RXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_VALID   = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_FERR    = 2;
  localparam int STAT_FULL    = 3;
  localparam int STAT_LVL_LSB = 8;

  function automatic logic [31:0] status_word(input logic valid, input logic ovr,
                                              input logic ferr, input logic full,
                                              input logic [7:0] level);
    logic [31:0] w;
    w = '0;
    w[STAT_VALID]          = valid;
    w[STAT_OVR]            = ovr;
    w[STAT_FERR]           = ferr;
    w[STAT_FULL]           = full;
    w[STAT_LVL_LSB +: 8]   = level;
    return w;
  endfunction

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Byte-wide synchronous FIFO for the UART receiver. A push into a full FIFO is
// ignored unless a pop happens in the same cycle; a pop from empty is ignored.
`timescale 1ns/1ps
module servant_uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [7:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = 8'(count);
  assign dout    = mem[rd_ptr];
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/servant_uart_rx.sv
// Wishbone UART receiver (8N1). Define SERVANT_UART_RX_FIFO_EN for a
// FIFO_DEPTH-entry receive FIFO; otherwise a single holding register is used.
`timescale 1ns/1ps
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int    CLKS_PER_BIT   = 139,
  parameter int    FIFO_DEPTH     = 4,
  parameter string RESET_STRATEGY = ""
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_rx,
  output logic        o_irq
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam bit RST_NONE_REQ = (RESET_STRATEGY == "NONE");

  logic             rx_meta, rx_s, rx_q;
  rx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_done, push_req, ferr_set;
  logic             acc, rd_pop, w1c, ovr_set;
  logic             ovr, ferr;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_level, head;
  logic             unused;

  assign unused = &{1'b0, i_wb_dat[31:3], i_wb_dat[0], RST_NONE_REQ, (FIFO_DEPTH > 0)};

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  // START checks mid-bit so a short low glitch falls back to IDLE.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rx_q && !rx_s) begin
          baud_cnt <= '0;
          state    <= ST_START;
        end
        ST_START: if (baud_cnt == HALF_LAST) begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= rx_s ? ST_IDLE : ST_DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        ST_DATA: if (baud_cnt == BIT_LAST) begin
          baud_cnt       <= '0;
          shreg[bit_idx] <= rx_s;
          bit_idx        <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= ST_STOP;
        end else baud_cnt <= baud_cnt + 1'b1;
        ST_STOP: if (baud_cnt == BIT_LAST) begin
          baud_cnt <= '0;
          state    <= ST_IDLE;
        end else baud_cnt <= baud_cnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stop_done = (state == ST_STOP) && (baud_cnt == BIT_LAST);
  assign push_req  = stop_done & rx_s;
  assign ferr_set  = stop_done & ~rx_s;

  assign acc     = i_wb_cyc & ~o_wb_ack;
  assign rd_pop  = acc & ~i_wb_we & (i_wb_adr == REG_RXDATA) & ~fifo_empty;
  assign w1c     = acc & i_wb_we & (i_wb_adr == REG_STATUS);
  assign ovr_set = push_req & fifo_full & ~rd_pop;

`ifdef SERVANT_UART_RX_FIFO_EN
  servant_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_wb_clk),
    .rst_n (i_wb_rst_n),
    .push  (push_req),
    .din   (shreg),
    .pop   (rd_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
`else
  logic       hold_vld;
  logic [7:0] hold_q;
  logic       hold_push;

  assign hold_push  = push_req & (~hold_vld | rd_pop);
  assign fifo_full  = hold_vld;
  assign fifo_empty = ~hold_vld;
  assign fifo_level = {7'b0, hold_vld};
  assign head       = hold_q;

  always_ff @(posedge i_wb_clk) begin
    if (hold_push) hold_q <= shreg;
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)    hold_vld <= 1'b0;
    else if (hold_push) hold_vld <= 1'b1;
    else if (rd_pop)    hold_vld <= 1'b0;
  end
`endif

  assign o_irq = ~fifo_empty;

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      o_wb_ack <= acc;
      if (acc && !i_wb_we) begin
        if (i_wb_adr == REG_RXDATA)
          o_wb_rdt <= {24'b0, fifo_empty ? 8'h00 : head};
        else
          o_wb_rdt <= status_word(~fifo_empty, ovr, ferr, fifo_full, fifo_level);
      end
      ovr  <= ovr_set  | (ovr  & ~(w1c & i_wb_dat[STAT_OVR]));
      ferr <= ferr_set | (ferr & ~(w1c & i_wb_dat[STAT_FERR]));
    end
  end

endmodule

// File: tb/tb_servant_uart_rx.sv
// Scoreboard bench for servant_uart_rx at 8 clocks per bit; expectations
// follow the FIFO or holding-register build selected by SERVANT_UART_RX_FIFO_EN.
`timescale 1ns/1ps
module tb_servant_uart_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef SERVANT_UART_RX_FIFO_EN
  localparam int MDEPTH = DEPTH;
`else
  localparam int MDEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adr = 1'b0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] dat = '0;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;
  int          rise_cyc;

  always #5 clk = ~clk;

  servant_uart_rx #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH     (DEPTH),
    .RESET_STRATEGY ("")
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_wb_adr   (adr),
    .i_wb_dat   (dat),
    .i_wb_we    (we),
    .i_wb_cyc   (cyc),
    .o_wb_rdt   (rdt),
    .o_wb_ack   (ack),
    .i_rx       (rx),
    .o_irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] w;
    w       = '0;
    w[0]    = (exp_q.size() != 0);
    w[1]    = m_ovr;
    w[2]    = m_ferr;
    w[3]    = (exp_q.size() == MDEPTH);
    w[15:8] = 8'(exp_q.size());
    return w;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    int cnt;
    cnt      = 0;
    rise_cyc = -1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      rx = 1'b0;
      else if (i == 9) rx = stop;
      else             rx = b[i-1];
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        cnt++;
        if (irq && rise_cyc < 0) rise_cyc = cnt;
      end
    end
    rx = 1'b1;
    for (int k = 0; k < CPB; k++) @(negedge clk);
    if (stop) begin
      if (exp_q.size() < MDEPTH) exp_q.push_back(b);
      else                       m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic wb_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; adr = a; we = 1'b0;
    @(negedge clk);
    check("ack_rd", 32'(ack), 32'd1);
    d   = rdt;
    cyc = 1'b0;
    @(negedge clk);
    check("ack_rd_drop", 32'(ack), 32'd0);
  endtask

  task automatic wb_write(input logic a, input logic [31:0] v);
    @(negedge clk);
    cyc = 1'b1; adr = a; we = 1'b1; dat = v;
    @(negedge clk);
    check("ack_wr", 32'(ack), 32'd1);
    cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    if (a == 1'b1) begin
      if (v[1]) m_ovr  = 1'b0;
      if (v[2]) m_ferr = 1'b0;
    end
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    wb_read(1'b0, d);
    e = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'd0;
    check(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    wb_read(1'b1, d);
    check(tag, d, model_status());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdt", rdt, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_status("status_after_rst");

    read_rx("rx_empty");
    read_status("status_empty_read");

    send_frame(8'hA5, 1'b1);
    check("valid_latency_window", 32'(rise_cyc >= 76 && rise_cyc <= 82), 32'd1);
    check("irq_pending", 32'(irq), 32'd1);
    read_status("status_a5");
    read_rx("rx_a5");
    read_status("status_after_pop");
    check("irq_clear", 32'(irq), 32'd0);

    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    read_status("status_glitch");

    send_frame(8'h3C, 1'b0);
    read_status("status_ferr");
    wb_write(1'b1, 32'h4);
    read_status("status_ferr_clr");

    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1);
    read_status("status_ovr");
    while (exp_q.size() != 0) read_rx("rx_fifo_order");
    read_rx("rx_drained");
    wb_write(1'b1, 32'h2);
    read_status("status_ovr_clr");

    send_frame(8'h5A, 1'b1);
    wb_write(1'b0, 32'hFF);
    read_status("status_rxdata_wr");
    read_rx("rx_5a");

    send_frame(8'h11, 1'b1);
    read_status("status_pre_abort");
    @(negedge clk); rx = 1'b0;
    repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_rdt", rdt, 32'd0);
    check("abort_irq", 32'(irq), 32'd0);
    exp_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_status("status_after_abort");
    send_frame(8'h7E, 1'b1);
    read_rx("rx_7e");
    read_status("status_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
